alarm_ctrl: RTL and testbench

- Decides when the piezo melody plays: an alarm match at a programmed hh:mm, or an hourly chime at mm:ss = 00:00.
- Drives `music_on`, which connects directly to the melody generator's active-high enable input. That generator restarts its melody whenever the enable is low.
- Sits between the time-keeping counters, the serial-configured alarm registers and the melody generator.
- Owns stop-button synchronisation and debounce, ring-duration timing, and chime/alarm arbitration.

---
 rtl/alarm_ctrl.sv | 156 +++++++++++++++
 tb/tb_alarm_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Decides when the piezo melody plays: alarm match at hh:mm:00 or hourly chime at mm:ss=00:00.
// Owns stop-button sync/debounce, ring-duration timing and chime/alarm arbitration.
module alarm_ctrl #(
    parameter int RING_SEC     = 60,
    parameter int CHIME_SEC    = 5,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_en,
    input  logic       chime_en,
    input  logic       stop_n,
    output logic       music_on,
    output logic       ring_alarm,
    output logic       ring_chime,
    output logic       alarm_fired
);

    localparam int               DW       = 20;
    localparam int               STAGES   = 1;
    localparam logic [DW-1:0]    DEB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [7:0]       RING_T   = 8'(RING_SEC);
    localparam logic [7:0]       CHIME_T  = 8'(CHIME_SEC);

    typedef enum logic [1:0] {IDLE, ALARM, CHIME, GAP} state_t;

    state_t            state;
    logic [7:0]        sec_cnt;
    logic              m_alarm_c, m_chime_c;
    logic [1:0]        m_q, m_d;
    logic [STAGES:0]   vld_pipe;
    logic              alarm_edge, chime_edge;
    logic [1:0]        sync;
    logic              deb, deb_last, press;
    logic [DW-1:0]     deb_cnt;

    assign m_alarm_c = alarm_en && (cur_hour == alarm_hour) && (cur_min == alarm_min)
                       && (cur_sec == 6'd0);
    assign m_chime_c = chime_en && (cur_min == 6'd0) && (cur_sec == 6'd0);

    // Edges are only trusted once m_d holds a real sample, so a match held
    // across reset release does not look like a fresh edge.
    assign alarm_edge = m_q[1] & ~m_d[1] & vld_pipe[STAGES];
    assign chime_edge = m_q[0] & ~m_d[0] & vld_pipe[STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q      <= '0;
            m_d      <= '0;
            vld_pipe <= '0;
        end else begin
            m_q      <= {m_alarm_c, m_chime_c};
            m_d      <= m_q;
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= 2'b11;
            deb      <= 1'b1;
            deb_last <= 1'b1;
            deb_cnt  <= '0;
            press    <= 1'b0;
        end else begin
            sync     <= {sync[0], stop_n};
            deb_last <= deb;
            press    <= deb_last & ~deb;
            if (sync[1] == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= sync[1];
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sec_cnt     <= '0;
            music_on    <= 1'b0;
            ring_alarm  <= 1'b0;
            ring_chime  <= 1'b0;
            alarm_fired <= 1'b0;
        end else begin
            alarm_fired <= 1'b0;
            case (state)
                IDLE: begin
                    if (alarm_edge) begin
                        state       <= ALARM;
                        sec_cnt     <= '0;
                        music_on    <= 1'b1;
                        ring_alarm  <= 1'b1;
                        alarm_fired <= 1'b1;
                    end else if (chime_edge) begin
                        state      <= CHIME;
                        sec_cnt    <= '0;
                        music_on   <= 1'b1;
                        ring_chime <= 1'b1;
                    end
                end
                ALARM: begin
                    if (press || !alarm_en || sec_cnt == RING_T) begin
                        state      <= IDLE;
                        sec_cnt    <= '0;
                        music_on   <= 1'b0;
                        ring_alarm <= 1'b0;
                    end else if (tick_1hz) begin
                        sec_cnt <= sec_cnt + 1'b1;
                    end
                end
                CHIME: begin
                    // Press beats a simultaneous alarm edge; that edge is then lost.
                    if (press || sec_cnt == CHIME_T) begin
                        state      <= IDLE;
                        sec_cnt    <= '0;
                        music_on   <= 1'b0;
                        ring_chime <= 1'b0;
                    end else if (alarm_edge) begin
                        state      <= GAP;
                        sec_cnt    <= '0;
                        music_on   <= 1'b0;
                        ring_chime <= 1'b0;
                    end else if (tick_1hz) begin
                        sec_cnt <= sec_cnt + 1'b1;
                    end
                end
                GAP: begin
                    // One low cycle makes the melody generator restart from note one.
                    state       <= ALARM;
                    sec_cnt     <= '0;
                    music_on    <= 1'b1;
                    ring_alarm  <= 1'b1;
                    alarm_fired <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    sec_cnt    <= '0;
                    music_on   <= 1'b0;
                    ring_alarm <= 1'b0;
                    ring_chime <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: alarm, chime, arbitration, preemption, stop debounce, reset.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic [4:0] cur_hour, alarm_hour;
    logic [5:0] cur_min, cur_sec, alarm_min;
    logic       alarm_en, chime_en, stop_n;
    logic       music_on, ring_alarm, ring_chime, alarm_fired;

    int n_chk = 0;
    int n_fail = 0;
    int fired_cnt = 0;
    int chime_seen = 0;
    int music_hi = 0;

    alarm_ctrl #(.RING_SEC(4), .CHIME_SEC(2), .DEBOUNCE_CYC(8)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .alarm_en(alarm_en), .chime_en(chime_en), .stop_n(stop_n),
        .music_on(music_on), .ring_alarm(ring_alarm), .ring_chime(ring_chime),
        .alarm_fired(alarm_fired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        fired_cnt += int'(alarm_fired);
        if (ring_chime) chime_seen = 1;
    endtask

    task automatic pulse();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hour = 5'(h);
        cur_min  = 6'(m);
        cur_sec  = 6'(s);
    endtask

    initial begin
        rst = 1'b1; tick_1hz = 1'b0; stop_n = 1'b1;
        alarm_en = 1'b0; chime_en = 1'b0; alarm_hour = '0; alarm_min = '0;
        set_time(0, 30, 15);
        repeat (3) step();
        chk("rst_music", music_on, 0);
        chk("rst_ring_alarm", ring_alarm, 0);
        chk("rst_ring_chime", ring_chime, 0);
        chk("rst_fired", alarm_fired, 0);
        rst = 1'b0;
        repeat (3) step();

        // Alarm 07:30 held for 10 ticks
        alarm_hour = 5'd7; alarm_min = 6'd30; alarm_en = 1'b1;
        set_time(7, 29, 59);
        step();
        fired_cnt = 0;
        set_time(7, 30, 0);
        step();
        chk("al_latency", music_on, 0);
        step();
        chk("al_on", music_on, 1);
        chk("al_ring", ring_alarm, 1);
        chk("al_fired", alarm_fired, 1);
        step();
        chk("al_fired_clr", alarm_fired, 0);
        for (int k = 1; k <= 4; k++) begin
            pulse();
            chk("al_ringing", music_on, 1);
        end
        step();
        chk("al_fall", music_on, 0);
        music_hi = 0;
        for (int k = 0; k < 6; k++) begin
            pulse();
            music_hi += int'(music_on);
        end
        chk("al_no_refire", music_hi, 0);
        chk("al_fired_once", fired_cnt, 1);

        // Hourly chime at 08:00:00
        alarm_en = 1'b0; chime_en = 1'b1;
        set_time(7, 59, 59);
        step();
        set_time(8, 0, 0);
        step();
        step();
        chk("ch_on", ring_chime, 1);
        chk("ch_music", music_on, 1);
        chk("ch_no_alarm", ring_alarm, 0);
        pulse();
        chk("ch_tick1", music_on, 1);
        pulse();
        chk("ch_tick2", music_on, 1);
        step();
        chk("ch_fall", music_on, 0);
        chk("ch_ring_fall", ring_chime, 0);

        // Chime disabled: no music
        set_time(8, 0, 5);
        chime_en = 1'b0;
        step();
        set_time(8, 0, 0);
        repeat (4) step();
        chk("ch_off_music", music_on, 0);
        chk("ch_off_ring", ring_chime, 0);

        // Alarm and chime on the same edge: alarm wins
        set_time(8, 59, 59);
        alarm_hour = 5'd9; alarm_min = 6'd0; alarm_en = 1'b1; chime_en = 1'b1;
        step();
        chime_seen = 0; fired_cnt = 0;
        set_time(9, 0, 0);
        step();
        step();
        chk("both_alarm", ring_alarm, 1);
        chk("both_no_chime", ring_chime, 0);
        for (int k = 0; k < 4; k++) pulse();
        step();
        chk("both_fall", music_on, 0);
        chk("both_chime_never", chime_seen, 0);
        chk("both_fired", fired_cnt, 1);

        // Alarm edge preempts a running chime through one GAP cycle
        set_time(9, 59, 59);
        alarm_hour = 5'd10; alarm_min = 6'd1;
        step();
        set_time(10, 0, 0);
        step();
        step();
        chk("pre_chime", ring_chime, 1);
        step();
        set_time(10, 1, 0);
        step();
        chk("pre_chime_hold", music_on, 1);
        step();
        chk("gap_music", music_on, 0);
        chk("gap_ring_chime", ring_chime, 0);
        chk("gap_ring_alarm", ring_alarm, 0);
        step();
        chk("pre_alarm_music", music_on, 1);
        chk("pre_alarm_ring", ring_alarm, 1);
        chk("pre_alarm_fired", alarm_fired, 1);
        chk("pre_alarm_cnt", dut.sec_cnt, 0);

        // 5-cycle glitch on stop_n is filtered
        stop_n = 1'b0;
        repeat (5) step();
        stop_n = 1'b1;
        repeat (15) step();
        chk("glitch_ignored", music_on, 1);

        // Real press: music falls 2+8+1+1 cycles after the pin drops
        stop_n = 1'b0;
        repeat (11) step();
        chk("press_pre", music_on, 1);
        step();
        chk("press_fall", music_on, 0);
        chk("press_ring", ring_alarm, 0);
        repeat (8) step();
        stop_n = 1'b1;
        repeat (15) step();

        // Async reset mid-ring
        set_time(10, 1, 1);
        step();
        set_time(10, 1, 0);
        step();
        step();
        chk("rst_pre", music_on, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_music", music_on, 0);
        chk("rst_async_ring", ring_alarm, 0);
        step();
        step();
        rst = 1'b0;
        fired_cnt = 0;
        repeat (6) step();
        chk("rst_hold_music", music_on, 0);
        chk("rst_hold_fired", fired_cnt, 0);
        set_time(10, 1, 1);
        step();
        set_time(10, 1, 0);
        step();
        step();
        chk("rst_fresh_music", music_on, 1);
        chk("rst_fresh_fired", alarm_fired, 1);

        // Disarming the alarm stops the ring
        alarm_en = 1'b0;
        step();
        chk("disarm_music", music_on, 0);
        chk("disarm_ring", ring_alarm, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
